// File: rtl/multi_sprite_drawer.sv
// Tile-sprite renderer: redraws a sprite only when its tile or direction changes, erasing the old tile first.
// First pixel leaves one cycle after selection, then 1 pixel/cycle; the output register holds while valid && !ready.
module multi_sprite_drawer #(
    parameter int N_SPR     = 2,
    parameter int CELL_SIZE = 8,
    parameter int MAZE_X0   = 0,
    parameter int MAZE_Y0   = 0,
    parameter int COORD_W   = 5,
    parameter int COLOR_W   = 9,
    parameter logic [COLOR_W-1:0] FLOOR_COLOR = '0
) (
    input  logic                                      i_clock,
    input  logic                                      i_reset,
    input  logic                                      i_enable,
    input  logic [N_SPR*COORD_W-1:0]                  i_tile_x,
    input  logic [N_SPR*COORD_W-1:0]                  i_tile_y,
    input  logic [N_SPR*2-1:0]                        i_dir,
    input  logic [N_SPR*COLOR_W-1:0]                  i_spr_color,
    output logic [((N_SPR > 1) ? $clog2(N_SPR) : 1)-1:0] o_q_idx,
    output logic [$clog2(CELL_SIZE)-1:0]              o_q_px,
    output logic [$clog2(CELL_SIZE)-1:0]              o_q_py,
    output logic [1:0]                                o_q_dir,
    input  logic                                      i_q_pixel,
    output logic [9:0]                                o_vga_x,
    output logic [8:0]                                o_vga_y,
    output logic [COLOR_W-1:0]                        o_vga_color,
    output logic                                      o_vga_valid,
    input  logic                                      i_vga_ready,
    output logic                                      o_clean
);
    localparam int IW = (N_SPR > 1) ? $clog2(N_SPR) : 1;
    localparam int PW = $clog2(CELL_SIZE);

    typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW} state_t;
    state_t r_state, w_next;

    logic [COORD_W-1:0] r_sh_x [N_SPR];
    logic [COORD_W-1:0] r_sh_y [N_SPR];
    logic [1:0]         r_sh_dir [N_SPR];
    logic [N_SPR-1:0]   r_sh_v;
    logic [IW-1:0]      r_rr_ptr, r_idx;
    logic [COORD_W-1:0] r_snap_x, r_snap_y;
    logic [1:0]         r_snap_dir;
    logic [COLOR_W-1:0] r_snap_col;
    logic [PW-1:0]      r_px, r_py;
    logic [9:0]         r_vga_x;
    logic [8:0]         r_vga_y;
    logic [COLOR_W-1:0] r_vga_color;
    logic               r_vga_valid;

    logic [COORD_W-1:0] w_tx [N_SPR];
    logic [COORD_W-1:0] w_ty [N_SPR];
    logic [1:0]         w_dir [N_SPR];
    logic [COLOR_W-1:0] w_col [N_SPR];
    logic [N_SPR-1:0]   w_dirty, w_rot;
    logic               w_found, w_sel_erase, w_load, w_start, w_last, w_emit;
    logic [IW-1:0]      w_sel;
    logic [IW:0]        w_cand;

    always_comb begin
        for (int i = 0; i < N_SPR; i++) begin
            w_tx[i]    = i_tile_x[i*COORD_W +: COORD_W];
            w_ty[i]    = i_tile_y[i*COORD_W +: COORD_W];
            w_dir[i]   = i_dir[i*2 +: 2];
            w_col[i]   = i_spr_color[i*COLOR_W +: COLOR_W];
            w_dirty[i] = !r_sh_v[i] || (r_sh_x[i] != w_tx[i]) || (r_sh_y[i] != w_ty[i])
                         || (r_sh_dir[i] != w_dir[i]);
        end
    end

    // Rotate so bit 0 is rr_ptr; the lowest set bit is the first dirty sprite round-robin.
    always_comb begin
        w_rot   = N_SPR'({w_dirty, w_dirty} >> r_rr_ptr);
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int k = N_SPR - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_cand  = {1'b0, r_rr_ptr} + (IW+1)'(k);
                if (w_cand >= (IW+1)'(N_SPR)) w_cand = w_cand - (IW+1)'(N_SPR);
                w_sel   = w_cand[IW-1:0];
            end
        end
    end

    assign w_sel_erase = r_sh_v[w_sel] && ((r_sh_x[w_sel] != w_tx[w_sel]) || (r_sh_y[w_sel] != w_ty[w_sel]));
    assign w_load      = !r_vga_valid || i_vga_ready;
    assign w_start     = (r_state == S_IDLE) && i_enable && w_found && w_load;
    assign w_last      = (&r_px) && (&r_py);
    assign w_emit      = w_start || (r_state != S_IDLE);

    // Pixel generator: in IDLE it presents pixel (0,0) of the candidate so the first write costs no bubble.
    logic [IW-1:0]      w_g_idx;
    logic [COORD_W-1:0] w_g_tx, w_g_ty;
    logic [PW-1:0]      w_g_px, w_g_py;
    logic [1:0]         w_g_dir;
    logic [COLOR_W-1:0] w_g_col;
    logic               w_g_erase;

    always_comb begin
        w_g_idx   = w_sel;
        w_g_tx    = w_sel_erase ? r_sh_x[w_sel] : w_tx[w_sel];
        w_g_ty    = w_sel_erase ? r_sh_y[w_sel] : w_ty[w_sel];
        w_g_px    = '0;
        w_g_py    = '0;
        w_g_dir   = w_dir[w_sel];
        w_g_col   = w_col[w_sel];
        w_g_erase = w_sel_erase;
        case (r_state)
            S_ERASE: begin
                w_g_idx = r_idx; w_g_tx = r_sh_x[r_idx]; w_g_ty = r_sh_y[r_idx];
                w_g_px = r_px; w_g_py = r_py; w_g_dir = r_snap_dir; w_g_col = r_snap_col;
                w_g_erase = 1'b1;
            end
            S_DRAW: begin
                w_g_idx = r_idx; w_g_tx = r_snap_x; w_g_ty = r_snap_y;
                w_g_px = r_px; w_g_py = r_py; w_g_dir = r_snap_dir; w_g_col = r_snap_col;
                w_g_erase = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = w_sel_erase ? S_ERASE : S_DRAW;
            S_ERASE: if (w_load && w_last) w_next = S_DRAW;
            S_DRAW:  if (w_load && w_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_vga_valid <= 1'b0;
            r_vga_x     <= '0;
            r_vga_y     <= '0;
            r_vga_color <= '0;
            r_sh_v      <= '0;
            r_rr_ptr    <= '0;
            r_idx       <= '0;
            r_snap_x    <= '0;
            r_snap_y    <= '0;
            r_snap_dir  <= '0;
            r_snap_col  <= '0;
            r_px        <= '0;
            r_py        <= '0;
            for (int i = 0; i < N_SPR; i++) begin
                r_sh_x[i]   <= '0;
                r_sh_y[i]   <= '0;
                r_sh_dir[i] <= '0;
            end
        end else begin
            if (w_load) begin
                r_vga_valid <= w_emit;
                if (w_emit) begin
                    r_vga_x     <= 10'(MAZE_X0 + int'(w_g_tx) * CELL_SIZE + int'(w_g_px));
                    r_vga_y     <= 9'(MAZE_Y0 + int'(w_g_ty) * CELL_SIZE + int'(w_g_py));
                    r_vga_color <= (w_g_erase || !i_q_pixel) ? FLOOR_COLOR : w_g_col;
                end
            end
            if (w_start) begin
                r_idx      <= w_sel;
                r_snap_x   <= w_tx[w_sel];
                r_snap_y   <= w_ty[w_sel];
                r_snap_dir <= w_dir[w_sel];
                r_snap_col <= w_col[w_sel];
                r_px       <= PW'(1);
                r_py       <= '0;
            end else if ((r_state != S_IDLE) && w_load) begin
                if (w_last) begin
                    r_px <= '0;
                    r_py <= '0;
                end else if (&r_px) begin
                    r_px <= '0;
                    r_py <= r_py + 1'b1;
                end else begin
                    r_px <= r_px + 1'b1;
                end
                // Erasing a shared tile wipes any other sprite standing on it, so force its redraw.
                if (w_last && (r_state == S_ERASE)) begin
                    for (int i = 0; i < N_SPR; i++) begin
                        if ((i != int'(r_idx)) && (r_sh_x[i] == r_sh_x[r_idx]) && (r_sh_y[i] == r_sh_y[r_idx]))
                            r_sh_v[i] <= 1'b0;
                    end
                end
                if (w_last && (r_state == S_DRAW)) begin
                    r_sh_x[r_idx]   <= r_snap_x;
                    r_sh_y[r_idx]   <= r_snap_y;
                    r_sh_dir[r_idx] <= r_snap_dir;
                    r_sh_v[r_idx]   <= 1'b1;
                    r_rr_ptr        <= (int'(r_idx) == N_SPR - 1) ? '0 : r_idx + 1'b1;
                end
            end
        end
    end

    assign o_q_idx     = w_g_idx;
    assign o_q_px      = w_g_px;
    assign o_q_py      = w_g_py;
    assign o_q_dir     = w_g_dir;
    assign o_vga_x     = r_vga_x;
    assign o_vga_y     = r_vga_y;
    assign o_vga_color = r_vga_color;
    assign o_vga_valid = r_vga_valid;
    assign o_clean     = (r_state == S_IDLE) && i_enable && !(|w_dirty);
endmodule

// File: tb/tb_multi_sprite_drawer.sv
// Table-driven bench for multi_sprite_drawer: each row moves sprites and lists the expected erase/draw segments.
module tb_multi_sprite_drawer;
    localparam int NS = 2, CS = 8, CW = 5, KW = 9;
    localparam int D_N = 0, D_E = 1, D_S = 2, D_W = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              reset, enable, q_pixel, vga_valid, vga_ready, clean;
    logic [NS*CW-1:0]  tile_x, tile_y;
    logic [NS*2-1:0]   dir;
    logic [NS*KW-1:0]  spr_color;
    logic [0:0]        q_idx;
    logic [2:0]        q_px, q_py;
    logic [1:0]        q_dir;
    logic [9:0]        vga_x;
    logic [8:0]        vga_y;
    logic [KW-1:0]     vga_color;

    multi_sprite_drawer #(.N_SPR(NS), .CELL_SIZE(CS), .MAZE_X0(0), .MAZE_Y0(0),
                          .COORD_W(CW), .COLOR_W(KW), .FLOOR_COLOR('0)) dut (
        .i_clock(clock), .i_reset(reset), .i_enable(enable),
        .i_tile_x(tile_x), .i_tile_y(tile_y), .i_dir(dir), .i_spr_color(spr_color),
        .o_q_idx(q_idx), .o_q_px(q_px), .o_q_py(q_py), .o_q_dir(q_dir), .i_q_pixel(q_pixel),
        .o_vga_x(vga_x), .o_vga_y(vga_y), .o_vga_color(vga_color), .o_vga_valid(vga_valid),
        .i_vga_ready(vga_ready), .o_clean(clean));

    function automatic logic shape(int idx, int d, int px, int py);
        return ((px + 2*py + 3*d + idx) % 3) == 0;
    endfunction
    function automatic int col_of(int i);
        return (i == 0) ? 'h1A5 : 'h0F3;
    endfunction
    assign q_pixel = shape(int'(q_idx), int'(q_dir), int'(q_px), int'(q_py));

    typedef struct { int x0, y0, d0, x1, y1, d1, stall_at, reset_at, qdir, seg0, nseg; } vec_t;
    typedef struct { int erase, idx, tx, ty, d; } seg_t;
    vec_t vt [7];
    seg_t st [14];

    int n_vec = 0, n_bad = 0, qdir_exp = -1, steps = 0;
    int got [$];
    int ex  [$];

    task automatic chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int pack_out();
        return (int'(vga_x) << 20) | (int'(vga_y) << 10) | int'(vga_color);
    endfunction

    task automatic step();
        @(negedge clock);
        if (qdir_exp >= 0 && vga_valid && got.size() < 60) chk("q_dir during draw", int'(q_dir), qdir_exp);
        if (vga_valid && vga_ready) got.push_back(pack_out());
        @(posedge clock);
        #1;
        steps++;
    endtask

    task automatic run_vec(int v);
        bit done, stalled;
        int hold, lim, c;
        got.delete();
        ex.delete();
        for (int s = vt[v].seg0; s < vt[v].seg0 + vt[v].nseg; s++)
            for (int py = 0; py < CS; py++)
                for (int px = 0; px < CS; px++) begin
                    c = (st[s].erase == 0 && shape(st[s].idx, st[s].d, px, py)) ? col_of(st[s].idx) : 0;
                    ex.push_back(((st[s].tx*CS + px) << 20) | ((st[s].ty*CS + py) << 10) | c);
                end
        tile_x[0 +: CW] = CW'(vt[v].x0);  tile_x[CW +: CW] = CW'(vt[v].x1);
        tile_y[0 +: CW] = CW'(vt[v].y0);  tile_y[CW +: CW] = CW'(vt[v].y1);
        dir[1:0] = 2'(vt[v].d0);          dir[3:2] = 2'(vt[v].d1);
        enable = 1'b1;
        vga_ready = 1'b1;
        qdir_exp = vt[v].qdir;
        done = 0; stalled = 0; steps = 0;
        while (steps < 2000) begin
            if (vt[v].reset_at >= 0 && got.size() == vt[v].reset_at) begin done = 1; break; end
            if (vt[v].reset_at < 0 && got.size() >= ex.size() && clean && !vga_valid) begin done = 1; break; end
            if (!stalled && got.size() == vt[v].stall_at) begin
                stalled = 1;
                hold = pack_out();
                vga_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    step();
                    chk($sformatf("v%0d stall hold %0d", v, k), vga_valid ? pack_out() : -1, hold);
                end
                vga_ready = 1'b1;
            end
            step();
            if (steps == 1) chk($sformatf("v%0d first valid", v), int'(vga_valid), 1);
        end
        qdir_exp = -1;
        chk($sformatf("v%0d completed in budget", v), int'(done), 1);
        if (vt[v].reset_at < 0) begin
            chk($sformatf("v%0d pixel count", v), got.size(), ex.size());
            chk($sformatf("v%0d cycles", v), steps, ex.size() + 1 + (stalled ? 5 : 0));
        end
        lim = (got.size() < ex.size()) ? got.size() : ex.size();
        for (int i = 0; i < lim; i++) chk($sformatf("v%0d pixel %0d", v, i), got[i], ex[i]);
    endtask

    initial begin
        // x0 y0 d0  x1 y1 d1  stall reset qdir seg0 nseg
        vt[0] = '{1, 1, D_E, 3, 2, D_S, -1, -1, -1,  0, 2};
        vt[1] = '{2, 1, D_E, 3, 2, D_S, -1, -1, -1,  2, 2};
        vt[2] = '{2, 1, D_N, 3, 2, D_S, 20, -1, D_N, 4, 1};
        vt[3] = '{2, 1, D_N, 2, 1, D_S, -1, -1, -1,  5, 2};
        vt[4] = '{2, 2, D_N, 2, 1, D_S, -1, -1, -1,  7, 3};
        vt[5] = '{1, 1, D_W, 2, 1, D_S, -1, 94, -1, 10, 2};
        vt[6] = '{1, 1, D_W, 2, 1, D_S, -1, -1, -1, 12, 2};
        // erase idx tx ty dir
        st[0]  = '{0, 0, 1, 1, D_E};  st[1]  = '{0, 1, 3, 2, D_S};
        st[2]  = '{1, 0, 1, 1, D_E};  st[3]  = '{0, 0, 2, 1, D_E};
        st[4]  = '{0, 0, 2, 1, D_N};
        st[5]  = '{1, 1, 3, 2, D_S};  st[6]  = '{0, 1, 2, 1, D_S};
        st[7]  = '{1, 0, 2, 1, D_N};  st[8]  = '{0, 0, 2, 2, D_N};  st[9] = '{0, 1, 2, 1, D_S};
        st[10] = '{1, 0, 2, 2, D_N};  st[11] = '{0, 0, 1, 1, D_W};
        st[12] = '{0, 0, 1, 1, D_W};  st[13] = '{0, 1, 2, 1, D_S};

        reset = 1'b1; enable = 1'b0; vga_ready = 1'b1;
        tile_x = '0; tile_y = '0; dir = '0;
        spr_color = {9'h0F3, 9'h1A5};
        step(); step();
        chk("reset valid", int'(vga_valid), 0);
        chk("reset x/y/color", pack_out(), 0);
        enable = 1'b1;
        step();
        chk("reset clean with enable", int'(clean), 0);
        chk("reset valid with enable", int'(vga_valid), 0);
        reset = 1'b0;

        for (int v = 0; v < 5; v++) run_vec(v);
        chk("clean after moves", int'(clean), 1);

        // Reset lands while pixel 30 of the redraw is pending.
        run_vec(5);
        reset = 1'b1; enable = 1'b0; vga_ready = 1'b0;
        step();
        chk("mid-scan reset valid", int'(vga_valid), 0);
        chk("mid-scan reset x/y/color", pack_out(), 0);
        reset = 1'b0; vga_ready = 1'b1;
        step(); step();
        chk("idle while disabled", int'(vga_valid), 0);
        run_vec(6);
        chk("clean after redraw", int'(clean), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
